// File: rtl/rf_wr_sched_pkg.sv
// Shared definitions for the write-back register-file write scheduler:
// opcode encodings, the buffered multiplier entry and the pipeline-side
// write decode.
package rf_wr_sched_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_SUBI = 6'b011111;
  localparam logic [5:0] OP_CALL = 6'b011000;
  localparam logic [5:0] OP_STW  = 6'b010101;
  localparam logic [5:0] OP_BLT  = 6'b010110;
  localparam logic [5:0] OP_NOPE = 6'b111111;

  // One multiplier return waiting for the write port.
  typedef struct packed {
    logic [5:0]  dest;
    logic [31:0] data;
  } b_entry_t;

  // Result of decoding the pipeline write-back slot.
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic       use_link;  // write the link value instead of the result
  } a_dec_t;

  // Which register (if any) the pipeline instruction writes. A register
  // field with bit 5 set is outside the file and suppresses the write.
  function automatic a_dec_t decode_a(input logic [5:0] opcode,
                                      input logic [5:0] dest,
                                      input logic [5:0] targ);
    a_dec_t d;
    d = '0;
    case (opcode)
      OP_ADD, OP_MUL: begin
        d.we   = ~targ[5];
        d.addr = targ[4:0];
      end
      OP_LDW, OP_ADDI, OP_SUBI: begin
        d.we   = ~dest[5];
        d.addr = dest[4:0];
      end
      OP_CALL: begin
        d.we       = 1'b1;
        d.addr     = LINK_REG;
        d.use_link = 1'b1;
      end
      OP_STW, OP_BLT, OP_NOPE: d = '0;
      default:                 d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rf_wr_sched_if.sv
// Request/response bundle between the write-back stage and the scheduler.
interface rf_wr_sched_if;
  logic        a_valid_46;
  logic [5:0]  a_opcode_46;
  logic [5:0]  a_dest_reg_46;
  logic [5:0]  a_targ_reg_46;
  logic [31:0] a_data1_46;
  logic [31:0] a_data2_46;
  logic        b_valid_46;
  logic        b_ready_46;
  logic [5:0]  b_dest_46;
  logic [31:0] b_data_46;
  logic        iss_valid_46;
  logic [5:0]  iss_dest_46;
  logic        rf_we_46;
  logic [4:0]  rf_waddr_46;
  logic [31:0] rf_wdata_46;
  logic [31:0] busy_mask_46;
  logic        wb_stall_46;
  logic        waw_err_46;

  // Pipeline / multiplier / issue side.
  modport master (
    output a_valid_46, a_opcode_46, a_dest_reg_46, a_targ_reg_46,
           a_data1_46, a_data2_46, b_valid_46, b_dest_46, b_data_46,
           iss_valid_46, iss_dest_46,
    input  b_ready_46, rf_we_46, rf_waddr_46, rf_wdata_46, busy_mask_46,
           wb_stall_46, waw_err_46
  );

  // Scheduler side.
  modport slave (
    input  a_valid_46, a_opcode_46, a_dest_reg_46, a_targ_reg_46,
           a_data1_46, a_data2_46, b_valid_46, b_dest_46, b_data_46,
           iss_valid_46, iss_dest_46,
    output b_ready_46, rf_we_46, rf_waddr_46, rf_wdata_46, busy_mask_46,
           wb_stall_46, waw_err_46
  );
endinterface

// File: rtl/rf_wr_sched_wb_fifo2.sv
// Two-entry FIFO buffering multiplier returns until the write port frees up.
module wb_fifo2
  import rf_wr_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  b_entry_t   i_entry,
  output b_entry_t   o_head,
  output logic [1:0] o_count
);

  b_entry_t   r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign w_push = i_push & (r_count != 2'd2);
  assign w_pop  = i_pop  & (r_count != 2'd0);

  // Entry storage.
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // Pointers and occupancy.
  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rf_wr_sched.sv
// Register-file write-port scheduler: pipeline results (A) take priority,
// buffered multiplier returns (B) fill idle slots, a scoreboard tracks
// pending multiplier destinations and an age counter requests an issue
// stall when the oldest B entry has waited too long.
module rf_wr_sched
  import rf_wr_sched_pkg::*;
#(
  parameter int AGE_MAX    = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk_46,
  input logic          rst_46,
  rf_wr_sched_if.slave bus
);

  localparam logic [3:0] AGE_LIMIT  = 4'(AGE_MAX);
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  a_dec_t         w_a_dec;
  b_entry_t       w_head;
  b_entry_t       w_b_entry;
  logic [1:0]     w_count;
  logic [1:0]     w_count_next;
  logic           w_a_win;
  logic           w_head_valid;
  logic           w_pop;
  logic           w_push;
  logic           w_b_commit;
  logic [NUM_REGS-1:0] w_busy_next;

  logic                r_b_ready;
  logic                r_rf_we;
  logic [4:0]          r_rf_waddr;
  logic [31:0]         r_rf_wdata;
  logic                r_waw;
  logic [3:0]          r_age;
  logic                r_stall;
  logic [NUM_REGS-1:0] r_busy;

  assign w_a_dec      = decode_a(bus.a_opcode_46, bus.a_dest_reg_46, bus.a_targ_reg_46);
  assign w_a_win      = bus.a_valid_46 & w_a_dec.we;
  assign w_head_valid = (w_count != 2'd0);
  assign w_pop        = w_head_valid & ~w_a_win;
  assign w_b_commit   = w_pop & ~w_head.dest[5];
  assign w_push       = bus.b_valid_46 & r_b_ready;
  assign w_b_entry    = '{dest: bus.b_dest_46, data: bus.b_data_46};
  assign w_count_next = w_count + {1'b0, w_push} - {1'b0, w_pop};

  wb_fifo2 u_fifo (
    .clk     (clk_46),
    .rst_n   (rst_46),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_b_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Registered ready so it stays low through reset and rises one edge later.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) r_b_ready <= 1'b0;
    else         r_b_ready <= (w_count_next != FULL_COUNT);
  end

  // Registered write port plus WAW flag aligned with the write.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_waw      <= 1'b0;
    end else begin
      r_rf_we <= w_a_win | w_b_commit;
      r_waw   <= w_a_win & r_busy[w_a_dec.addr];
      if (w_a_win) begin
        r_rf_waddr <= w_a_dec.addr;
        r_rf_wdata <= w_a_dec.use_link ? bus.a_data2_46 : bus.a_data1_46;
      end else if (w_b_commit) begin
        r_rf_waddr <= w_head.dest[4:0];
        r_rf_wdata <= w_head.data;
      end
    end
  end

  // Head-of-line age and the starvation stall it drives.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) begin
      r_age   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_pop || !w_head_valid) r_age <= '0;
      else if (r_age != 4'hF)     r_age <= r_age + 4'd1;

      if (w_pop)                                 r_stall <= 1'b0;
      else if (w_head_valid && r_age == AGE_LIMIT) r_stall <= 1'b1;
    end
  end

  // Scoreboard update: clear on B commit, then set on issue so set wins.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    w_busy_next = r_busy;
    if (w_b_commit) w_busy_next[w_head.dest[4:0]] = 1'b0;
    if (bus.iss_valid_46 && !bus.iss_dest_46[5]) w_busy_next[bus.iss_dest_46[4:0]] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) r_busy <= '0;
    else         r_busy <= w_busy_next;
  end

  assign bus.b_ready_46   = r_b_ready;
  assign bus.rf_we_46     = r_rf_we;
  assign bus.rf_waddr_46  = r_rf_waddr;
  assign bus.rf_wdata_46  = r_rf_wdata;
  assign bus.busy_mask_46 = r_busy;
  assign bus.wb_stall_46  = r_stall;
  assign bus.waw_err_46   = r_waw;

endmodule

// File: tb/tb_rf_wr_sched.sv
// Directed testbench for rf_wr_sched: inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_rf_wr_sched;
  import rf_wr_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  rf_wr_sched_if bus ();

  rf_wr_sched #(.AGE_MAX(8), .FIFO_DEPTH(2)) dut (
    .clk_46 (clk),
    .rst_46 (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  dest;
    logic [5:0]  targ;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } dec_vec_t;

  dec_vec_t dec_vecs [11] = '{
    '{OP_ADD,  6'd2,    6'd7,    32'h11, 32'h0,  1'b1, 5'd7,  32'h11},
    '{OP_CALL, 6'd3,    6'd4,    32'h99, 32'h40, 1'b1, 5'd31, 32'h40},
    '{OP_STW,  6'd5,    6'd6,    32'h1,  32'h2,  1'b0, 5'd0,  32'h0},
    '{OP_BLT,  6'd5,    6'd6,    32'h1,  32'h2,  1'b0, 5'd0,  32'h0},
    '{OP_NOPE, 6'd5,    6'd6,    32'h1,  32'h2,  1'b0, 5'd0,  32'h0},
    '{OP_LDW,  6'h25,   6'd1,    32'h3,  32'h0,  1'b0, 5'd0,  32'h0},
    '{OP_MUL,  6'd2,    6'd8,    32'h22, 32'h0,  1'b1, 5'd8,  32'h22},
    '{OP_ADDI, 6'd10,   6'd9,    32'h33, 32'h0,  1'b1, 5'd10, 32'h33},
    '{OP_SUBI, 6'd11,   6'd1,    32'h44, 32'h0,  1'b1, 5'd11, 32'h44},
    '{OP_ADD,  6'd2,    6'h21,   32'h5,  32'h0,  1'b0, 5'd0,  32'h0},
    '{OP_LDW,  6'd12,   6'd1,    32'h55, 32'h0,  1'b1, 5'd12, 32'h55}
  };

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    bus.a_valid_46    = 1'b0;
    bus.a_opcode_46   = OP_NOPE;
    bus.a_dest_reg_46 = '0;
    bus.a_targ_reg_46 = '0;
    bus.a_data1_46    = '0;
    bus.a_data2_46    = '0;
    bus.b_valid_46    = 1'b0;
    bus.b_dest_46     = '0;
    bus.b_data_46     = '0;
    bus.iss_valid_46  = 1'b0;
    bus.iss_dest_46   = '0;
  endtask

  task automatic drive_a(input logic [5:0] op, input logic [5:0] dest,
                         input logic [5:0] targ, input logic [31:0] d1,
                         input logic [31:0] d2);
    bus.a_valid_46    = 1'b1;
    bus.a_opcode_46   = op;
    bus.a_dest_reg_46 = dest;
    bus.a_targ_reg_46 = targ;
    bus.a_data1_46    = d1;
    bus.a_data2_46    = d2;
  endtask

  task automatic drive_b(input logic [5:0] dest, input logic [31:0] data);
    bus.b_valid_46 = 1'b1;
    bus.b_dest_46  = dest;
    bus.b_data_46  = data;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic seen_write;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.rf_we_46, bus.waw_err_46, bus.wb_stall_46, bus.b_ready_46, bus.busy_mask_46} !== 36'h0)
      $display("FAIL rst_outputs: got we=%b waw=%b stall=%b rdy=%b busy=%h want all 0",
               bus.rf_we_46, bus.waw_err_46, bus.wb_stall_46, bus.b_ready_46, bus.busy_mask_46);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus.b_ready_46 !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", bus.b_ready_46);
    else n_pass++;

    // Fill the FIFO behind continuous A writes and mark r5/r9 busy.
    drive_a(OP_ADD, 6'd0, 6'd1, 32'h1, 32'h0);
    drive_b(6'd5, 32'h55);
    bus.iss_valid_46 = 1'b1; bus.iss_dest_46 = 6'd5;
    tick();
    drive_b(6'd9, 32'h99);
    bus.iss_dest_46 = 6'd9;
    tick();
    bus.b_valid_46 = 1'b0; bus.iss_valid_46 = 1'b0;
    tick();
    n_total++;
    if ({bus.b_ready_46, bus.busy_mask_46} !== {1'b0, 32'h0000_0220})
      $display("FAIL rst_prefill: got rdy=%b busy=%h want rdy=0 busy=00000220",
               bus.b_ready_46, bus.busy_mask_46);
    else n_pass++;

    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.rf_we_46, bus.b_ready_46, bus.busy_mask_46, bus.wb_stall_46} !== 35'h0)
      $display("FAIL rst_async: got we=%b rdy=%b busy=%h stall=%b want all 0",
               bus.rf_we_46, bus.b_ready_46, bus.busy_mask_46, bus.wb_stall_46);
    else n_pass++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus.b_ready_46 !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", bus.b_ready_46);
    else n_pass++;
    seen_write = bus.rf_we_46;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_write |= bus.rf_we_46;
    end
    n_total++;
    if (seen_write !== 1'b0) $display("FAIL rst_dropped_entries: got write=%b want 0", seen_write);
    else n_pass++;
  endtask

  task automatic test_decode;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive_a(dec_vecs[i].op, dec_vecs[i].dest, dec_vecs[i].targ, dec_vecs[i].d1, dec_vecs[i].d2);
      tick();
      bus.a_valid_46 = 1'b0;
      n_total++;
      if (bus.rf_we_46 !== dec_vecs[i].we)
        $display("FAIL decode_we[%0d]: got %b want %b", i, bus.rf_we_46, dec_vecs[i].we);
      else n_pass++;
      if (dec_vecs[i].we) begin
        n_total++;
        if ({bus.rf_waddr_46, bus.rf_wdata_46} !== {dec_vecs[i].addr, dec_vecs[i].data})
          $display("FAIL decode_wr[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i,
                   bus.rf_waddr_46, bus.rf_wdata_46, dec_vecs[i].addr, dec_vecs[i].data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_priority;
    logic [31:0] exp_data;
    do_reset();
    drive_b(6'd3, 32'hAA);
    bus.iss_valid_46 = 1'b1; bus.iss_dest_46 = 6'd3;
    tick();
    bus.b_valid_46 = 1'b0; bus.iss_valid_46 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_data = 32'h100 + 32'(i);
      drive_a(OP_ADDI, 6'd4, 6'd0, exp_data, 32'h0);
      tick();
      n_total++;
      if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.waw_err_46} !== {1'b1, 5'd4, exp_data, 1'b0})
        $display("FAIL prio_a[%0d]: got we=%b addr=%0d data=%h waw=%b want we=1 addr=4 data=%h waw=0",
                 i, bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.waw_err_46, exp_data);
      else n_pass++;
    end
    n_total++;
    if (bus.busy_mask_46[3] !== 1'b1) $display("FAIL prio_busy_held: got %b want 1", bus.busy_mask_46[3]);
    else n_pass++;
    drive_a(OP_NOPE, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();
    idle();
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46} !== {1'b1, 5'd3, 32'hAA})
      $display("FAIL prio_b_commit: got we=%b addr=%0d data=%h want we=1 addr=3 data=000000aa",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46);
    else n_pass++;
    n_total++;
    if (bus.busy_mask_46[3] !== 1'b0) $display("FAIL prio_busy_clr: got %b want 0", bus.busy_mask_46[3]);
    else n_pass++;
  endtask

  task automatic test_starvation;
    do_reset();
    drive_b(6'd20, 32'h77);
    tick();
    bus.b_valid_46 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive_a(OP_ADD, 6'd0, 6'd1, 32'(k), 32'h0);
      tick();
      if (k == 8) begin
        n_total++;
        if (bus.wb_stall_46 !== 1'b0) $display("FAIL starve_early: got %b want 0", bus.wb_stall_46);
        else n_pass++;
      end
      if (k == 9) begin
        n_total++;
        if (bus.wb_stall_46 !== 1'b1) $display("FAIL starve_rise: got %b want 1", bus.wb_stall_46);
        else n_pass++;
      end
    end
    drive_a(OP_NOPE, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();
    idle();
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.wb_stall_46} !== {1'b1, 5'd20, 32'h77, 1'b0})
      $display("FAIL starve_commit: got we=%b addr=%0d data=%h stall=%b want we=1 addr=20 data=00000077 stall=0",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.wb_stall_46);
    else n_pass++;
  endtask

  task automatic test_full_simul;
    do_reset();
    drive_a(OP_ADD, 6'd0, 6'd1, 32'h0, 32'h0);
    drive_b(6'd6, 32'h1);
    bus.iss_valid_46 = 1'b1; bus.iss_dest_46 = 6'd6;
    n_total++;
    if (bus.b_ready_46 !== 1'b1) $display("FAIL full_rdy0: got %b want 1", bus.b_ready_46);
    else n_pass++;
    tick();
    drive_b(6'd7, 32'h2);
    bus.iss_valid_46 = 1'b0;
    n_total++;
    if (bus.b_ready_46 !== 1'b1) $display("FAIL full_rdy1: got %b want 1", bus.b_ready_46);
    else n_pass++;
    tick();
    drive_b(6'd8, 32'h3);
    n_total++;
    if (bus.b_ready_46 !== 1'b0) $display("FAIL full_rdy2: got %b want 0", bus.b_ready_46);
    else n_pass++;
    tick();
    // A goes idle, head (r6) commits while issue re-marks r6 busy.
    bus.a_valid_46 = 1'b0;
    bus.iss_valid_46 = 1'b1; bus.iss_dest_46 = 6'd6;
    tick();
    bus.iss_valid_46 = 1'b0;
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46} !== {1'b1, 5'd6, 32'h1})
      $display("FAIL full_c6: got we=%b addr=%0d data=%h want we=1 addr=6 data=00000001",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46);
    else n_pass++;
    n_total++;
    if (bus.busy_mask_46[6] !== 1'b1) $display("FAIL full_set_wins: got %b want 1", bus.busy_mask_46[6]);
    else n_pass++;
    n_total++;
    if (bus.b_ready_46 !== 1'b1) $display("FAIL full_rdy_back: got %b want 1", bus.b_ready_46);
    else n_pass++;
    tick();
    bus.b_valid_46 = 1'b0;
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46} !== {1'b1, 5'd7, 32'h2})
      $display("FAIL full_c7: got we=%b addr=%0d data=%h want we=1 addr=7 data=00000002",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46} !== {1'b1, 5'd8, 32'h3})
      $display("FAIL full_c8_held: got we=%b addr=%0d data=%h want we=1 addr=8 data=00000003",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46);
    else n_pass++;
    tick();
    n_total++;
    if (bus.rf_we_46 !== 1'b0) $display("FAIL full_empty: got we=%b want 0", bus.rf_we_46);
    else n_pass++;
  endtask

  task automatic test_waw;
    do_reset();
    bus.iss_valid_46 = 1'b1; bus.iss_dest_46 = 6'd12;
    tick();
    n_total++;
    if (bus.busy_mask_46 !== 32'h0000_1000) $display("FAIL waw_busy_set: got %h want 00001000", bus.busy_mask_46);
    else n_pass++;
    bus.iss_dest_46 = 6'h2D;
    drive_a(OP_ADD, 6'd0, 6'd12, 32'h5, 32'h0);
    tick();
    idle();
    n_total++;
    if ({bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.waw_err_46} !== {1'b1, 5'd12, 32'h5, 1'b1})
      $display("FAIL waw_pulse: got we=%b addr=%0d data=%h waw=%b want we=1 addr=12 data=00000005 waw=1",
               bus.rf_we_46, bus.rf_waddr_46, bus.rf_wdata_46, bus.waw_err_46);
    else n_pass++;
    n_total++;
    if (bus.busy_mask_46 !== 32'h0000_1000) $display("FAIL waw_iss_bit5: got %h want 00001000", bus.busy_mask_46);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.rf_we_46, bus.waw_err_46} !== 2'b00)
      $display("FAIL waw_one_cycle: got we=%b waw=%b want 0 0", bus.rf_we_46, bus.waw_err_46);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_priority();
    test_starvation();
    test_full_simul();
    test_waw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
